sevseg_decimal_formatter: RTL

- Converts a binary value, signed or unsigned, into per-digit 5-bit display codes for a bank of `sevseg_display` decoders.
- Uses sequential double-dabble.
- Applies leading-zero blanking and a minus sign (`SEVSEG_LINE_INDEX`).
- Sits between the processor's register/result output and the seven-segment decoders, and holds the last formatted result so the display never flickers mid-conversion.

---
 rtl/lab_pkg.sv | 16 +
 rtl/bcd_shift_step.sv | 26 ++
 rtl/sevseg_decimal_formatter.sv | 118 +++++++++++
 3 files changed

// File: rtl/lab_pkg.sv
// Shared display-side types and code points for the lab codebase.
// Seven-segment decoders treat codes 0-9 as numerals plus the two special indices below.
package lab_pkg;

    localparam logic [4:0] SEVSEG_BLANK_INDEX = 5'd16;
    localparam logic [4:0] SEVSEG_LINE_INDEX  = 5'd17;

    typedef logic [4:0] sevseg_code_t;

    typedef enum logic [1:0] {
        FMT_IDLE,
        FMT_CONVERT,
        FMT_FORMAT
    } fmt_state_t;

endpackage

// File: rtl/bcd_shift_step.sv
// One combinational double-dabble step: add-3 on every nibble >= 5,
// then shift {bcd, magnitude} left by one bit.
module bcd_shift_step #(
    parameter int BCD_DIGITS = 5,
    parameter int DATA_WIDTH = 16
) (
    input  logic [BCD_DIGITS*4-1:0] bcd_in,
    input  logic [DATA_WIDTH-1:0]   mag_in,
    output logic [BCD_DIGITS*4-1:0] bcd_out,
    output logic [DATA_WIDTH-1:0]   mag_out
);

    logic [BCD_DIGITS*4-1:0] bcd_adj;

    always_comb begin
        bcd_adj = bcd_in;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_in[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_in[i*4 +: 4] + 4'd3;
            end
        end
    end

    assign {bcd_out, mag_out} = {bcd_adj, mag_in} << 1;

endmodule

// File: rtl/sevseg_decimal_formatter.sv
// Binary (signed or unsigned) to per-digit seven-segment codes via sequential double-dabble,
// with leading-zero blanking, a minus sign and an all-dashes overflow indication.
module sevseg_decimal_formatter
    import lab_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_DIGITS = 6,
    parameter int SIGNED     = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [DATA_WIDTH-1:0]               in_value,
    input  logic                                in_valid,
    output logic                                in_ready,
    output sevseg_code_t [NUM_DIGITS-1:0]       digit_codes,
    output logic                                out_valid,
    output fmt_state_t                          dbg_state
);

    localparam int BCD_DIGITS = (DATA_WIDTH * 3) / 10 + 1;
    localparam int EXT_DIGITS = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
    localparam int CW         = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);

    fmt_state_t              state_q, state_d;
    logic                    sign_q;
    logic [DATA_WIDTH-1:0]   mag_q, mag_nxt;
    logic [BCD_DIGITS*4-1:0] bcd_q, bcd_nxt;
    logic [CW-1:0]           cnt_q;

    logic [EXT_DIGITS*4-1:0] bcd_ext;
    int                      msd;
    logic                    show_minus;
    logic                    overflow;
    sevseg_code_t [NUM_DIGITS-1:0] codes_d;

    // Handshake: a value transfers on a rising edge where in_valid && in_ready;
    // in_ready is a pure decode of the registered state, so it never depends on in_valid.
    assign in_ready  = (state_q == FMT_IDLE);
    assign dbg_state = state_q;

    bcd_shift_step #(
        .BCD_DIGITS(BCD_DIGITS),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .bcd_in (bcd_q),
        .mag_in (mag_q),
        .bcd_out(bcd_nxt),
        .mag_out(mag_nxt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            FMT_IDLE:    if (in_valid) state_d = FMT_CONVERT;
            FMT_CONVERT: if (cnt_q == LAST_STEP) state_d = FMT_FORMAT;
            FMT_FORMAT:  state_d = FMT_IDLE;
            default:     state_d = FMT_IDLE;
        endcase
    end

    // Digit formatting from the finished BCD: numerals up to the top nonzero digit.
    always_comb begin
        bcd_ext = '0;
        bcd_ext[BCD_DIGITS*4-1:0] = bcd_q;
        msd = 0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] != 4'd0) msd = i;
        end
        show_minus = sign_q && (bcd_q != '0);
        overflow   = (msd + 1 + (show_minus ? 1 : 0)) > NUM_DIGITS;
        codes_d    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (overflow)                           codes_d[i] = SEVSEG_LINE_INDEX;
            else if (i <= msd)                      codes_d[i] = {1'b0, bcd_ext[i*4 +: 4]};
            else if (show_minus && (i == msd + 1))  codes_d[i] = SEVSEG_LINE_INDEX;
            else                                    codes_d[i] = SEVSEG_BLANK_INDEX;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FMT_IDLE;
            sign_q    <= 1'b0;
            mag_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) digit_codes[i] <= SEVSEG_BLANK_INDEX;
        end else begin
            state_q   <= state_d;
            out_valid <= 1'b0;
            case (state_q)
                FMT_IDLE: begin
                    if (in_valid) begin
                        // Negation at full width keeps the most negative value's magnitude exact.
                        sign_q <= (SIGNED != 0) && in_value[DATA_WIDTH-1];
                        mag_q  <= ((SIGNED != 0) && in_value[DATA_WIDTH-1]) ?
                                  (~in_value + 1'b1) : in_value;
                        bcd_q  <= '0;
                        cnt_q  <= '0;
                    end
                end
                FMT_CONVERT: begin
                    bcd_q <= bcd_nxt;
                    mag_q <= mag_nxt;
                    cnt_q <= cnt_q + 1'b1;
                end
                FMT_FORMAT: begin
                    digit_codes <= codes_d;
                    out_valid   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
